fifo_rd_stream: RTL and testbench

- Read-side front end for the async FIFO; lives entirely in the read clock domain.
- Converts the FIFO pop interface (empty / red_enable / rdata) into a valid/ready stream with a 2-entry skid buffer, so downstream back-pressure never drops a word.
- Provides run/drain control, a busy flag and a delivered-word counter.

---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/skid_buf2.sv | 63 ++++++
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_rd_stream.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream front end.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; head register drives data_out directly.
// The caller guarantees no push into a full buffer and no pop from an empty one.
module skid_buf2 #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out,
  output logic [1:0]       cnt
);

  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;

  // Next-state: a push lands behind the current contents, a pop shifts tail into head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = data_in;
        else               tail_d = data_in;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; head advances.
        if (cnt_q == 2'd1) begin
          head_d = data_in;
        end else begin
          head_d = tail_q;
          tail_d = data_in;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out = head_q;
  assign cnt      = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side front end of the async FIFO: turns empty/red_enable/rdata into a
// valid/ready stream through a 2-entry skid buffer, with run/drain control.
// Optional packet framing (m_last) is built when FIFO_RD_PKT_LAST_EN is defined.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int width   = 32,
  parameter int CNT_W   = 16,
  parameter int PKT_LEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             empty,
  input  logic [width-1:0] rdata,
  output logic             red_enable,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
`ifdef FIFO_RD_PKT_LAST_EN
  output logic             m_last,
`endif
  output logic [CNT_W-1:0] word_cnt
);

  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("PKT_LEN must be at least 1");
  end

  rd_state_e        state_q, state_d;
  logic             infl_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [1:0]       cnt;
  logic             pop;
  logic [2:0]       occ_next;

  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign busy    = (state_q != IDLE);

  // Occupancy once this cycle's landing and pop settle; a new read is only
  // issued if its word will still fit when it lands next cycle.
  assign occ_next   = {1'b0, cnt} + {2'b0, infl_q} - {2'b0, pop};
  assign red_enable = (state_q == RUN) & go & ~empty & (occ_next < 3'(SKID_DEPTH));

  skid_buf2 #(.width(width)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (infl_q),
    .pop      (pop),
    .data_in  (rdata),
    .data_out (m_data),
    .cnt      (cnt)
  );

  // Run/drain control; DRAIN lets outstanding words finish before going idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (go) state_d = RUN;
      RUN:   if (!go) state_d = ((cnt != 2'd0) || infl_q) ? DRAIN : IDLE;
      DRAIN: begin
        if (go)                              state_d = RUN;
        else if ((cnt == 2'd0) && !infl_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, in-flight flag and delivered-word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      infl_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= red_enable;
      if (pop) word_cnt_q <= word_cnt_q + CNT_W'(1);
    end
  end

  assign word_cnt = word_cnt_q;

`ifdef FIFO_RD_PKT_LAST_EN
  localparam int PKT_W = clog2_min1(PKT_LEN);

  logic [PKT_W-1:0] pkt_cnt_q;

  assign m_last = m_valid & (pkt_cnt_q == PKT_W'(PKT_LEN - 1));

  // Position within the current packet; survives DRAIN/IDLE, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pkt_cnt_q <= '0;
    else if (pop)   pkt_cnt_q <= m_last ? '0 : pkt_cnt_q + PKT_W'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized self-checking bench for fifo_rd_stream with a queue-based FIFO and
// stream scoreboard.
module tb_fifo_rd_stream;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          empty = 1'b1;
  logic [W-1:0]  rdata = '0;
  logic          m_ready = 1'b0;
  logic          red_enable, m_valid, busy;
  logic [W-1:0]  m_data;
  logic [CW-1:0] word_cnt;
`ifdef FIFO_RD_PKT_LAST_EN
  logic          m_last;
`endif

  fifo_rd_stream #(.width(W), .CNT_W(CW), .PKT_LEN(PL)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .empty      (empty),
    .rdata      (rdata),
    .red_enable (red_enable),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
`ifdef FIFO_RD_PKT_LAST_EN
    .m_last     (m_last),
`endif
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] src[$];     // words still in the FIFO
  logic [W-1:0] exp_q[$];   // words popped from the FIFO, not yet delivered
  int           delivered;
  logic         pend;
  logic [W-1:0] pend_w;
  logic         held;
  logic [W-1:0] held_d;
  logic         re_last;
  int cyc, re_cnt, first_re, last_re, first_vld, beats;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) src.push_back($urandom());
  endtask

  // One clock: drive inputs at negedge, check, then model the FIFO pop at posedge.
  task automatic step(input logic g, input logic r, input logic s);
    @(negedge clk);
    rdata   = pend ? pend_w : $urandom();
    go      = g;
    m_ready = r;
    empty   = (src.size() == 0) || s;
    #1;
    cyc++;
    chk("word_cnt", word_cnt, 64'(CW'(delivered)));
    if (red_enable) begin
      chk("re_while_empty", empty, 0);
      chk("re_without_go", go, 1);
      re_cnt++;
      if (first_re < 0) first_re = cyc;
      last_re = cyc;
    end
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (exp_q.size() == 0) chk("spurious_valid", m_valid, 0);
    if (held) begin
      chk("held_valid", m_valid, 1);
      chk("held_data", m_data, held_d);
    end
`ifdef FIFO_RD_PKT_LAST_EN
    if (m_valid) chk("m_last", m_last, ((delivered + 1) % PL) == 0);
`endif
    if (m_valid && m_ready && exp_q.size() > 0) begin
      chk("m_data", m_data, exp_q.pop_front());
      delivered++;
      beats++;
    end
    held    = m_valid && !m_ready;
    held_d  = m_data;
    re_last = red_enable;
    @(posedge clk);
    pend = re_last && (src.size() > 0);
    if (pend) begin
      pend_w = src.pop_front();
      exp_q.push_back(pend_w);
    end
  endtask

  task automatic drain(input int budget, input logic g);
    int k = 0;
    while ((src.size() > 0 || exp_q.size() > 0) && k < budget) begin
      step(g, 1'b1, 1'b0);
      k++;
    end
    chk("drain_timeout", (src.size() == 0 && exp_q.size() == 0), 1);
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_red_enable", red_enable, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    src.delete();
    exp_q.delete();
    pend = 0; held = 0; delivered = 0;
    go = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base, n_out;
    logic [W-1:0] w0;
    delivered = 0; pend = 0; held = 0; cyc = 0; re_cnt = 0; beats = 0;
    first_re = -1; last_re = -1; first_vld = -1;

    // Reset state
    #1;
    chk("init_red_enable", red_enable, 0);
    chk("init_m_valid", m_valid, 0);
    chk("init_m_data", m_data, 0);
    chk("init_busy", busy, 0);
    chk("init_word_cnt", word_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Five words, free-flowing stream: latency and back-to-back reads
    fill(5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("t1_re_pulses", re_cnt, 5);
    chk("t1_re_consecutive", last_re - first_re + 1, 5);
    chk("t1_latency", first_vld - first_re, 2);
    #1 chk("t1_word_cnt", word_cnt, 5);

    // Back-pressure from the start: exactly two reads, head held
    re_cnt = 0;
    fill(10);
    w0 = src[0];
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    chk("t2_re_pulses", re_cnt, 2);
    chk("t2_held", held, 1);
    chk("t2_head", held_d, w0);
    base = delivered;
    drain(60, 1'b1);
    chk("t2_delivered", delivered - base, 10);

    // Empty toggling every other cycle
    base = delivered;
    fill(8);
    for (int k = 0; k < 60 && (src.size() > 0 || exp_q.size() > 0); k++)
      step(1'b1, 1'b1, (cyc % 2) == 0);
    chk("t3_delivered", delivered - base, 8);

    // Drop go with a full skid buffer: outstanding words finish, no new reads
    fill(6);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    n_out = exp_q.size();
    chk("t4_outstanding", n_out, 2);
    beats = 0;
    step(1'b0, 1'b1, 1'b0);
    #1 chk("t4_drain_busy", busy, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    chk("t4_beats", beats, n_out);
    chk("t4_src_untouched", src.size(), 4);
    #1 chk("t4_idle_busy", busy, 0);

    // Reset in the middle of a back-pressured burst
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    #1 chk("t5_pre_valid", m_valid, 1);
    do_reset();

    // Packet framing across a DRAIN/IDLE gap
    fill(10);
    drain(60, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    fill(2);
    drain(30, 1'b1);
    chk("t6_delivered", delivered, 12);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if (src.size() < 3 && ($urandom % 4) == 0) fill($urandom_range(1, 6));
      step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 4) == 0);
    end
    drain(100, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    #1 chk("rand_idle_busy", busy, 0);
    chk("rand_word_cnt", word_cnt, 64'(CW'(delivered)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
